// File: rtl/psx_ddr_mem_responder.sv
// psx_ddr_mem_responder
//   Avalon-MM slave standing in for the DDR controller behind the PSX DDR
//   bridge. 64-bit words in on-chip RAM, fixed read latency, optional
//   LFSR-driven wait-request injection.
//
// Ports
//   clk               clock
//   i_nrst            asynchronous active-low reset
//   i_targetAddr      word address, sampled on command acceptance
//   i_burstLength     burst beats (0 treated as 1 and flagged)
//   o_busyMem         wait request; acceptance only when low
//   i_writeEnableMem  write command / write beat
//   i_readEnableMem   read command
//   i_dataMem         write data
//   i_byteEnableMem   write byte enables, bit n gates byte n
//   o_dataValidMem    read data valid
//   o_dataMem         read data (holds last word when not valid)
//   o_protoErr        sticky protocol-violation flag
module psx_ddr_mem_responder #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned STALL_EN     = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic [16:0] i_targetAddr,
    input  logic [2:0]  i_burstLength,
    output logic        o_busyMem,
    input  logic        i_writeEnableMem,
    input  logic        i_readEnableMem,
    input  logic [63:0] i_dataMem,
    input  logic [7:0]  i_byteEnableMem,
    output logic        o_dataValidMem,
    output logic [63:0] o_dataMem,
    output logic        o_protoErr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_DATA
    } state_t;

    // RD_WAIT lasts READ_LATENCY-1 cycles; counter counts down to zero.
    localparam logic [3:0] LAT_INIT = (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_beatRem;
    logic [3:0]        r_latCnt;
    logic [15:0]       r_lfsr;
    logic              r_dataValid;
    logic [63:0]       r_data;
    logic              r_protoErr;
    logic [63:0]       r_mem [2**ADDR_W];

    logic              w_stall;
    logic              w_busy;
    logic [ADDR_W-1:0] w_cmdAddr;
    logic [2:0]        w_cmdLen;
    logic              w_idleWr;
    logic              w_idleRd;
    logic              w_idleBoth;
    logic              w_burstWr;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic              w_lfsrFb;

    assign w_stall    = (STALL_EN != 0) && (r_lfsr[1:0] == 2'b00) &&
                        ((r_state == ST_IDLE) || (r_state == ST_WR_BURST));
    assign w_busy     = (r_state == ST_RD_WAIT) || (r_state == ST_RD_DATA) || w_stall;
    assign w_cmdAddr  = i_targetAddr[ADDR_W-1:0];
    assign w_cmdLen   = (i_burstLength == 3'd0) ? 3'd1 : i_burstLength;
    assign w_idleWr   = (r_state == ST_IDLE) && !w_busy && i_writeEnableMem && !i_readEnableMem;
    assign w_idleRd   = (r_state == ST_IDLE) && !w_busy && i_readEnableMem && !i_writeEnableMem;
    assign w_idleBoth = (r_state == ST_IDLE) && !w_busy && i_readEnableMem && i_writeEnableMem;
    assign w_burstWr  = (r_state == ST_WR_BURST) && !w_busy && i_writeEnableMem;
    // Gated by reset so a write presented while reset is held never lands.
    assign w_memWe    = i_nrst && (w_idleWr || w_burstWr);
    assign w_memAddr  = (r_state == ST_IDLE) ? w_cmdAddr : r_addr;
    assign w_lfsrFb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    assign o_busyMem      = w_busy;
    assign o_dataValidMem = r_dataValid;
    assign o_dataMem      = r_data;
    assign o_protoErr     = r_protoErr;

    // RAM is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (i_byteEnableMem[b]) begin
                    r_mem[w_memAddr][b*8 +: 8] <= i_dataMem[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_beatRem   <= '0;
            r_latCnt    <= '0;
            r_lfsr      <= LFSR_SEED;
            r_dataValid <= 1'b0;
            r_data      <= '0;
            r_protoErr  <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
            case (r_state)
                ST_IDLE: begin
                    if (w_idleBoth) begin
                        r_protoErr <= 1'b1;
                    end else if (w_idleWr) begin
                        // Beat 0 is written by the RAM block this edge.
                        if (i_burstLength == 3'd0) r_protoErr <= 1'b1;
                        r_addr    <= w_cmdAddr + 1'b1;
                        r_beatRem <= w_cmdLen - 3'd1;
                        if (w_cmdLen > 3'd1) r_state <= ST_WR_BURST;
                    end else if (w_idleRd) begin
                        if (i_burstLength == 3'd0) r_protoErr <= 1'b1;
                        if (READ_LATENCY <= 1) begin
                            // Zero wait cycles: first beat issues straight away.
                            r_state     <= ST_RD_DATA;
                            r_dataValid <= 1'b1;
                            r_data      <= r_mem[w_cmdAddr];
                            r_addr      <= w_cmdAddr + 1'b1;
                            r_beatRem   <= w_cmdLen - 3'd1;
                        end else begin
                            r_state   <= ST_RD_WAIT;
                            r_addr    <= w_cmdAddr;
                            r_beatRem <= w_cmdLen;
                            r_latCnt  <= LAT_INIT;
                        end
                    end
                end
                ST_WR_BURST: begin
                    if (i_readEnableMem) r_protoErr <= 1'b1;
                    if (w_burstWr) begin
                        r_addr    <= r_addr + 1'b1;
                        r_beatRem <= r_beatRem - 3'd1;
                        if (r_beatRem == 3'd1) r_state <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_latCnt == 4'd0) begin
                        r_state     <= ST_RD_DATA;
                        r_dataValid <= 1'b1;
                        r_data      <= r_mem[r_addr];
                        r_addr      <= r_addr + 1'b1;
                        r_beatRem   <= r_beatRem - 3'd1;
                    end else begin
                        r_latCnt <= r_latCnt - 4'd1;
                    end
                end
                ST_RD_DATA: begin
                    // r_beatRem counts beats still to issue after the current one.
                    if (r_beatRem != 3'd0) begin
                        r_data    <= r_mem[r_addr];
                        r_addr    <= r_addr + 1'b1;
                        r_beatRem <= r_beatRem - 3'd1;
                    end else begin
                        r_dataValid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
